seq_detect_scheduler: RTL and testbench

Shares one serial "101" Moore pattern detector between NREQ requesters using round-robin arbitration.
- Each grant latches the winner's parallel word and clears the detector.
- The word is shifted into the detector MSB first, one bit per clock, and the 1-cycles of the detector output are counted.
- A one-cycle done pulse reports the requester id and its hit count.
- Sits between parallel producers and the serial detector datapath.

---
 rtl/seq_detect_pkg.sv | 18 +
 rtl/seq101_detector.sv | 41 ++++
 rtl/seq_detect_scheduler.sv | 147 ++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encodings for the scheduler and its 101 detector
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FLUSH = 2'b10,
        DONE  = 2'b11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

endpackage

// File: rtl/seq101_detector.sv
// rtl/seq101_detector.sv - overlapping "101" Moore detector with sync clear and enable
module seq101_detector
    import seq_detect_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic det_out
);

    det_state_t state;
    det_state_t state_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = S0;
        end else if (en) begin
            case (state)
                S0:      state_next = bit_in ? S1 : S0;
                S1:      state_next = bit_in ? S1 : S2;
                S2:      state_next = bit_in ? S3 : S0;
                S3:      state_next = bit_in ? S1 : S2;
                default: state_next = S0;
            endcase
        end
    end

    assign det_out = (state == S3);

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - round-robin sharing of one serial 101 detector among NREQ word producers
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD_W-1:0]   word_in,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     det_bit,
    output logic                     det_out,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [CNT_W-1:0]         hit_count
);

    localparam int               BC_W     = $clog2(WORD_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   job_id;
    logic [WORD_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_inc;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic [WORD_W-1:0] word_sel;
    logic              det_clr;
    logic              det_en;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                word_sel = word_in[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state == IDLE && found) begin
            grant[winner] = 1'b1;
        end
    end

    assign acc_inc = (det_out && acc != CNT_MAX) ? acc + 1'b1 : acc;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign det_bit = (state == SHIFT) ? shift_reg[WORD_W-1] : 1'b0;

    always_comb begin
        state_next = state;
        det_clr    = 1'b0;
        det_en     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    det_clr    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NREQ - 1);
            job_id    <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            done_id   <= '0;
            hit_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        shift_reg <= word_sel;
                        job_id    <= winner;
                        rr_ptr    <= winner;
                        bit_cnt   <= '0;
                        acc       <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                    acc       <= acc_inc;
                end
                // The last bit's hit only shows on det_out here, so results latch on leaving FLUSH.
                FLUSH: begin
                    acc       <= acc_inc;
                    done_id   <= job_id;
                    hit_count <= acc_inc;
                end
                default: ;
            endcase
        end
    end

    seq101_detector u_detector (
        .clock   (clock),
        .reset   (reset),
        .clr     (det_clr),
        .en      (det_en),
        .bit_in  (det_bit),
        .det_out (det_out)
    );

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - directed scoreboard bench for seq_detect_scheduler
module tb_seq_detect_scheduler;

    localparam int NREQ   = 4;
    localparam int WORD_W = 8;

    logic                   clock;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word_in;

    logic [NREQ-1:0] grant,   grant_c1;
    logic            busy,    busy_c1;
    logic            det_bit, det_bit_c1;
    logic            det_out, det_out_c1;
    logic            done,    done_c1;
    logic [1:0]      done_id, done_id_c1;
    logic [3:0]      hit_count;
    logic [0:0]      hit_count_c1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int cnt;
        int cnt1;
    } exp_t;
    exp_t sb[$];

    seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .req(req), .word_in(word_in),
        .grant(grant), .busy(busy), .det_bit(det_bit), .det_out(det_out),
        .done(done), .done_id(done_id), .hit_count(hit_count)
    );

    seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(1)) dut_c1 (
        .clock(clock), .reset(reset), .req(req), .word_in(word_in),
        .grant(grant_c1), .busy(busy_c1), .det_bit(det_bit_c1), .det_out(det_out_c1),
        .done(done_c1), .done_id(done_id_c1), .hit_count(hit_count_c1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int count101(input logic [7:0] w, input int cw);
        int n = 0;
        for (int i = 7; i >= 2; i--) begin
            if (w[i] == 1'b1 && w[i-1] == 1'b0 && w[i-2] == 1'b1) n++;
        end
        if (n > (1 << cw) - 1) n = (1 << cw) - 1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done();
        exp_t e;
        chk("done", 32'(done), 32'd1);
        chk("done_c1", 32'(done_c1), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_id", 32'(done_id), 32'(e.id));
            chk("done_id_c1", 32'(done_id_c1), 32'(e.id));
            chk("hit_count", 32'(hit_count), 32'(e.cnt));
            chk("hit_count_c1", 32'(hit_count_c1), 32'(e.cnt1));
        end
    endtask

    // Entered at the grant cycle (negedge + 1); ends at the done cycle.
    task automatic finish_job(input logic [7:0] w, input int id, input bit keep);
        sb.push_back('{id, count101(w, 4), count101(w, 1)});
        chk("busy_at_grant", 32'(busy), 32'd0);
        chk("grant_c1", 32'(grant_c1), 32'(grant));
        for (int k = 0; k < WORD_W; k++) begin
            @(negedge clock); #1;
            if (k == 0 && !keep) req = '0;
            chk($sformatf("det_bit%0d", k), 32'(det_bit), 32'(w[7-k]));
            chk("busy_shift", 32'(busy), 32'd1);
        end
        @(negedge clock); #1;
        chk("done_early", 32'(done), 32'd0);
        @(negedge clock); #1;
        check_done();
        chk("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic do_job(input logic [3:0] r, input int id, input bit keep);
        int waited = 0;
        logic [7:0] w;
        @(negedge clock);
        req = r;
        #1;
        while (grant == '0 && waited < 60) begin
            @(negedge clock); #1;
            waited++;
        end
        chk("grant", 32'(grant), 32'(1 << id));
        chk("grant_wait", 32'(waited), 32'd0);
        w = word_in[id*WORD_W +: WORD_W];
        finish_job(w, id, keep);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_det_bit"}, 32'(det_bit), 32'd0);
        chk({tag, "_det_out"}, 32'(det_out), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, "_c1"}, 32'({grant_c1, busy_c1, det_bit_c1, det_out_c1, done_c1, done_id_c1, hit_count_c1}), 32'd0);
    endtask

    initial begin
        bit seen_done;
        logic [7:0] w;

        reset   = 1'b1;
        req     = '0;
        word_in = '0;
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        word_in[7:0] = 8'b1010_0101;
        do_job(4'b0001, 0, 1'b0);
        word_in[7:0] = 8'b1010_1010;
        do_job(4'b0001, 0, 1'b0);
        word_in[7:0] = 8'h00;
        do_job(4'b0001, 0, 1'b0);
        word_in[7:0] = 8'hFF;
        do_job(4'b0001, 0, 1'b0);
        word_in[7:0] = 8'b0000_0101;
        do_job(4'b0001, 0, 1'b0);

        // Fresh reset so rotation begins at requester 0.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        word_in = {8'b1011_0101, 8'b0101_1010, 8'b1101_1011, 8'b1010_0101};
        do_job(4'b1111, 0, 1'b1);
        do_job(4'b1111, 1, 1'b1);
        do_job(4'b1111, 2, 1'b1);
        do_job(4'b1111, 3, 1'b1);
        do_job(4'b1111, 0, 1'b0);

        // Abort mid-SHIFT with reset.
        word_in[7:0] = 8'b1010_0101;
        @(negedge clock);
        req = 4'b0001;
        #1;
        chk("abort_grant", 32'(grant), 32'h1);
        repeat (4) @(negedge clock);
        #1;
        reset = 1'b1;
        req   = '0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clock); #1;
            if (done || done_c1) seen_done = 1'b1;
        end
        chk("no_done_after_abort", 32'(seen_done), 32'd0);
        word_in[23:16] = 8'b1010_0101;
        do_job(4'b0100, 2, 1'b0);

        // req1 only while busy, req2 rising in DONE.
        word_in[7:0] = 8'b1010_1010;
        @(negedge clock);
        req = 4'b0001;
        #1;
        chk("busy_req_grant", 32'(grant), 32'h1);
        w = word_in[7:0];
        sb.push_back('{0, count101(w, 4), count101(w, 1)});
        @(negedge clock); #1;
        req = 4'b0010;
        repeat (7) @(negedge clock);
        #1;
        req = '0;
        @(negedge clock);
        @(negedge clock); #1;
        check_done();
        req = 4'b0100;
        #1;
        chk("no_grant_in_done", 32'(grant), 32'd0);
        @(negedge clock); #1;
        chk("grant_after_done", 32'(grant), 32'h4);
        finish_job(word_in[23:16], 2, 1'b0);

        repeat (3) @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
